// File: rtl/apu_i2s_tx_if.sv
// Signal bundle between the APU mixer side and the I2S transmitter.
// The master drives the sample and control inputs; the slave (transmitter) drives the codec pins.
interface apu_i2s_tx_if;
   logic        cpu_clk_en;
   logic        enable;
   logic [15:0] audio_in;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        frame_strobe;

   modport master (
      output cpu_clk_en, enable, audio_in,
      input  bclk, lrclk, sdata, frame_strobe
   );

   modport slave (
      input  cpu_clk_en, enable, audio_in,
      output bclk, lrclk, sdata, frame_strobe
   );
endinterface

// File: rtl/apu_i2s_tx.sv
// I2S transmitter for the APU mono mix: same word in both slots, BCLK/LRCLK derived from clk.
// Optional box-filter decimation of audio_in is enabled by defining APU_I2S_AVG_EN.
module apu_i2s_tx #(
   parameter int BCLK_DIV = 4,
   parameter int AVG_LOG2 = 4
) (
   input logic          clk,
   input logic          rst,
   apu_i2s_tx_if.slave  bus
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0] r_divCnt;
   logic [4:0]       r_bitCnt;
   logic             r_bclk;
   logic             r_lrclk;
   logic             r_sdata;
   logic             r_frameStrobe;
   logic [15:0]      r_txWord;

   logic             w_divWrap;
   logic             w_fall;
   logic [4:0]       w_nextBit;
   logic [15:0]      w_source;
   logic [15:0]      w_latchWord;
   logic [15:0]      w_wordForBit;
   logic [3:0]       w_bitIdx;

`ifdef APU_I2S_AVG_EN
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = 16 + AVG_LOG2;

   logic [15:0]      r_hist [DEPTH];
   logic [SUM_W-1:0] r_sum;

   // History runs regardless of enable; the latch reads r_sum before this edge's update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_hist[i] <= '0;
         end
         r_sum <= '0;
      end else if (bus.cpu_clk_en) begin
         r_hist[0] <= bus.audio_in;
         for (int i = 1; i < DEPTH; i++) begin
            r_hist[i] <= r_hist[i-1];
         end
         r_sum <= r_sum + SUM_W'(bus.audio_in) - SUM_W'(r_hist[DEPTH-1]);
      end
   end

   assign w_source = r_sum[SUM_W-1:AVG_LOG2];
`else
   logic w_unusedCfg;

   assign w_source    = bus.audio_in;
   assign w_unusedCfg = bus.cpu_clk_en ^ (AVG_LOG2 > 0);
`endif

   // Slot bit k carries word bit (16-k) mod 16, which also covers both LSB positions (k=0, k=16).
   always_comb begin
      w_divWrap    = (r_divCnt == DIV_LAST);
      w_fall       = w_divWrap && r_bclk;
      w_nextBit    = r_bitCnt + 5'd1;
      w_latchWord  = {~w_source[15], w_source[14:0]};
      w_wordForBit = (w_nextBit == 5'd1) ? w_latchWord : r_txWord;
      w_bitIdx     = 4'd0 - w_nextBit[3:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divCnt      <= '0;
         r_bitCnt      <= '0;
         r_bclk        <= 1'b0;
         r_lrclk       <= 1'b0;
         r_sdata       <= 1'b0;
         r_frameStrobe <= 1'b0;
         r_txWord      <= '0;
      end else if (!bus.enable) begin
         r_divCnt      <= '0;
         r_bitCnt      <= '0;
         r_bclk        <= 1'b0;
         r_lrclk       <= 1'b0;
         r_sdata       <= 1'b0;
         r_frameStrobe <= 1'b0;
      end else begin
         r_frameStrobe <= 1'b0;
         if (w_divWrap) begin
            r_divCnt <= '0;
            r_bclk   <= ~r_bclk;
         end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
         end
         if (w_fall) begin
            r_bitCnt <= w_nextBit;
            r_lrclk  <= w_nextBit[4];
            r_sdata  <= w_wordForBit[w_bitIdx];
            if (w_nextBit == 5'd1) begin
               r_txWord      <= w_latchWord;
               r_frameStrobe <= 1'b1;
            end
         end
      end
   end

   assign bus.bclk         = r_bclk;
   assign bus.lrclk        = r_lrclk;
   assign bus.sdata        = r_sdata;
   assign bus.frame_strobe = r_frameStrobe;

endmodule

// File: tb/tb_apu_i2s_tx.sv
// Bench for apu_i2s_tx: time-based reference model checked every cycle, plus literal frame captures.
// Covers the APU_I2S_AVG_EN build as well when that macro is defined for both files.
module tb_apu_i2s_tx;

   localparam int BCLK_DIV   = 2;
   localparam int AVG_LOG2   = 4;
   localparam int BIT_CLKS   = 2 * BCLK_DIV;
   localparam int FRAME_CLKS = 64 * BCLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   checkEn = 1'b0;

   apu_i2s_tx_if bus();

   apu_i2s_tx #(.BCLK_DIV(BCLK_DIV), .AVG_LOG2(AVG_LOG2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic cpuEn, input logic [15:0] audio);
      bus.enable     = en;
      bus.cpu_clk_en = cpuEn;
      bus.audio_in   = audio;
   endtask

   // Reference model: mT counts enabled clocks since the transmitter last started,
   // and every output is derived from that count and the word latched at bit 1.
   int          mT;
   logic [15:0] mWord;
   logic [15:0] mSrc;
`ifdef APU_I2S_AVG_EN
   logic [15:0] mHist [$];

   function automatic logic [15:0] avgSource();
      int s = 0;
      foreach (mHist[i]) s += int'(mHist[i]);
      return 16'(s >> AVG_LOG2);
   endfunction
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mT    = 0;
         mWord = '0;
`ifdef APU_I2S_AVG_EN
         mHist = {};
         for (int i = 0; i < (1 << AVG_LOG2); i++) mHist.push_back(16'h0000);
`endif
      end else begin
`ifdef APU_I2S_AVG_EN
         mSrc = avgSource();
         if (bus.cpu_clk_en) begin
            mHist.push_back(bus.audio_in);
            void'(mHist.pop_front());
         end
`else
         mSrc = bus.audio_in;
`endif
         if (bus.enable) mT++;
         else            mT = 0;
         if (mT > 0 && (mT % BIT_CLKS) == 0 && ((mT / BIT_CLKS) % 32) == 1)
            mWord = {~mSrc[15], mSrc[14:0]};
      end
   end

   function automatic logic expSdata(input int t, input logic [15:0] w);
      int n = t / BIT_CLKS;
      int k = n % 32;
      if (n == 0) return 1'b0;
      if (k == 0 || k == 16) return w[0];
      if (k < 16) return w[16 - k];
      return w[32 - k];
   endfunction

   int cN;
   int cK;

   always @(negedge clk) begin
      if (checkEn && !rst) begin
         cN = mT / BIT_CLKS;
         cK = cN % 32;
         checkOutput("bclk",  32'(bus.bclk),  32'((mT / BCLK_DIV) % 2));
         checkOutput("lrclk", 32'(bus.lrclk), 32'(cK >= 16));
         checkOutput("sdata", 32'(bus.sdata), 32'(expSdata(mT, mWord)));
         checkOutput("frame_strobe", 32'(bus.frame_strobe),
                     32'(mT > 0 && (mT % BIT_CLKS) == 0 && cK == 1));
      end
   end

   task automatic waitStrobe(input string tag, input bit startNow, input int budget,
                             output bit ok, output int clocks);
      ok = 1'b0;
      clocks = 0;
      if (startNow && bus.frame_strobe === 1'b1) begin
         ok = 1'b1;
         return;
      end
      while (clocks < budget) begin
         @(negedge clk);
         clocks++;
         if (bus.frame_strobe === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("[TB] FAIL %s: no frame_strobe within %0d clocks", tag, budget);
   endtask

   // Shifts out one frame starting at a strobe; optionally changes audio_in right after the latch.
   task automatic captureSlots(input string tag, input logic [15:0] expWord, input bit startNow,
                               input bit doChange, input logic [15:0] newVal);
      logic [15:0] left;
      logic [15:0] right;
      bit ok;
      int clocks;
      waitStrobe({tag, " strobe"}, startNow, 400, ok, clocks);
      if (!ok) return;
      checkOutput({tag, " model word"}, 32'(mWord), 32'(expWord));
      left  = '0;
      right = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < 16) left  = {left[14:0],  bus.sdata};
         else        right = {right[14:0], bus.sdata};
         if (i == 0)  checkOutput({tag, " lrclk at left MSB"}, 32'(bus.lrclk), 32'd0);
         if (i == 15) checkOutput({tag, " lrclk at left LSB"}, 32'(bus.lrclk), 32'd1);
         if (i == 31) checkOutput({tag, " lrclk at right LSB"}, 32'(bus.lrclk), 32'd0);
         if (i == 0 && doChange) bus.audio_in = newVal;
         repeat (BIT_CLKS) @(negedge clk);
      end
      checkOutput({tag, " left slot"},  32'(left),  32'(expWord));
      checkOutput({tag, " right slot"}, 32'(right), 32'(expWord));
   endtask

`ifdef APU_I2S_AVG_EN
   task automatic pushSamples(input int count, input logic [15:0] val);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         bus.cpu_clk_en = 1'b1;
         bus.audio_in   = val;
         @(negedge clk);
         bus.cpu_clk_en = 1'b0;
      end
   endtask
`endif

   initial begin
      bit ok;
      int clocks;
      int offLeft;

      // Reset state and asynchronous reset in the middle of a frame.
      applyStimulus(1'b0, 1'b0, 16'h0000);
      repeat (3) @(negedge clk);
      checkOutput("reset bclk",  32'(bus.bclk),  32'd0);
      checkOutput("reset lrclk", 32'(bus.lrclk), 32'd0);
      checkOutput("reset sdata", 32'(bus.sdata), 32'd0);
      checkOutput("reset frame_strobe", 32'(bus.frame_strobe), 32'd0);
      rst = 1'b0;
      checkEn = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'h1234);
      repeat (40) @(negedge clk);
      clocks = 0;
      while (bus.bclk !== 1'b1 && clocks < 20) begin
         @(negedge clk);
         clocks++;
      end
      checkOutput("bclk high before mid-frame reset", 32'(bus.bclk), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset bclk",  32'(bus.bclk),  32'd0);
      checkOutput("async reset lrclk", 32'(bus.lrclk), 32'd0);
      checkOutput("async reset sdata", 32'(bus.sdata), 32'd0);
      checkOutput("async reset frame_strobe", 32'(bus.frame_strobe), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      waitStrobe("first strobe after reset", 1'b0, 20, ok, clocks);
      if (ok) checkOutput("first strobe latency", 32'(clocks), 32'(2 * BCLK_DIV));
      waitStrobe("second strobe after reset", 1'b0, 400, ok, clocks);
      if (ok) checkOutput("strobe spacing", 32'(clocks), 32'(FRAME_CLKS));

`ifdef APU_I2S_AVG_EN
      // Box-filter averaging: eight then sixteen pushes of 0x9000 from a cleared history.
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      pushSamples(8, 16'h9000);
      @(negedge clk);
      bus.enable = 1'b1;
      captureSlots("avg of 8", 16'hC800, 1'b0, 1'b0, 16'h0000);
      bus.enable = 1'b0;
      pushSamples(8, 16'h9000);
      @(negedge clk);
      bus.enable = 1'b1;
      captureSlots("avg of 16", 16'h1000, 1'b0, 1'b0, 16'h0000);
`else
      // Offset-binary conversion at the extremes and a source change inside a frame.
      @(negedge clk);
      bus.audio_in = 16'hFFFF;
      captureSlots("full scale", 16'h7FFF, 1'b0, 1'b0, 16'h0000);
      bus.audio_in = 16'h8000;
      captureSlots("midscale", 16'h0000, 1'b0, 1'b0, 16'h0000);
      bus.audio_in = 16'h0000;
      captureSlots("zero", 16'h8000, 1'b0, 1'b0, 16'h0000);
      bus.audio_in = 16'h1234;
      captureSlots("before change", 16'h9234, 1'b0, 1'b1, 16'hABCD);
      captureSlots("after change", 16'h2BCD, 1'b1, 1'b0, 16'h0000);
`endif

      // Drop enable at bit 9, hold it low, then restart from a fresh frame.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'hFFFF);
      waitStrobe("strobe before disable", 1'b0, 400, ok, clocks);
      repeat (8 * BIT_CLKS) @(negedge clk);
      checkOutput("lrclk at bit 9", 32'(bus.lrclk), 32'd0);
`ifdef APU_I2S_AVG_EN
      checkOutput("sdata at bit 9", 32'(bus.sdata), 32'd0);
`else
      checkOutput("sdata at bit 9", 32'(bus.sdata), 32'd1);
`endif
      bus.enable = 1'b0;
      @(negedge clk);
      checkOutput("disabled bclk",  32'(bus.bclk),  32'd0);
      checkOutput("disabled lrclk", 32'(bus.lrclk), 32'd0);
      checkOutput("disabled sdata", 32'(bus.sdata), 32'd0);
      repeat (9) @(negedge clk);
      bus.enable = 1'b1;
      waitStrobe("strobe after re-enable", 1'b0, 20, ok, clocks);
      if (ok) checkOutput("re-enable strobe latency", 32'(clocks), 32'(2 * BCLK_DIV));

      // Random samples every cycle, random history pushes and occasional enable drops.
      offLeft = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (offLeft == 0 && $urandom_range(0, 499) == 0) offLeft = $urandom_range(1, 20);
         applyStimulus(offLeft == 0, $urandom_range(0, 3) == 0, 16'($urandom));
         if (offLeft > 0) offLeft--;
      end

      @(negedge clk);
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apu_i2s_tx.md
Name: apu_i2s_tx

Overview:
Audio-side consumer of the APU mixer output.
- Takes the 16-bit unsigned mixed sample (audio_out of the APU) and serializes it as standard I2S to an external DAC.
- Generates BCLK/LRCLK from the system clock.
- Sends the same mono sample in both the left and right slots.
- Sits between the APU top and the board audio codec pins.

Parameters:
- BCLK_DIV, 4, clk cycles per BCLK half-period (legal ≥1); frame = 64*BCLK_DIV clk cycles
- AVG_LOG2, 4, log2 of averaging window depth (used only with the optional feature)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cpu_clk_en  input  1  one-cycle strobe, CPU-rate tick (sample-history push, optional feature)
- enable  input  1  level; 1 = transmitter running
- audio_in  input  16  unsigned offset-binary sample from APU mixer
- bclk  output  1  I2S bit clock
- lrclk  output  1  I2S word select; 0 = left slot, 1 = right slot
- sdata  output  1  I2S serial data, MSB first
- frame_strobe  output  1  one-cycle pulse when a new sample is latched

Behaviour:
- Reset: all outputs 0. Internally div_cnt=0, bit_cnt=0, tx_word=0, history/sum=0.
- All outputs are registered.
- Sample format: tx_word = {~s[15], s[14:0]}, where s is audio_in (or the average when the feature is on). Examples: 0x8000→0x0000, 0xFFFF→0x7FFF, 0x0000→0x8000.
- Divider, when enable=1:
  - div_cnt counts 0..BCLK_DIV-1.
  - At BCLK_DIV-1, bclk toggles and div_cnt→0.
  - A toggle 1→0 is a "fall event".
- Fall event:
  - bit_cnt ← (bit_cnt+1) mod 32.
  - lrclk ← new bit_cnt[4].
  - sdata updated in the same clk.
- Data mapping for the new bit_cnt k (I2S one-bit delay after LRCLK edge):
  - k=1: latch tx_word from current source; sdata=tx_word[15]; frame_strobe=1 for that clk.
  - k=2..15: sdata=tx_word[16-k].
  - k=16: sdata=tx_word[0] (left LSB; lrclk already 1).
  - k=17..31: sdata=tx_word[32-k].
  - k=0: sdata=tx_word[0] (right LSB; lrclk already 0).
- tx_word is stable from one latch to the next, so both slots carry the same word.
- Latch source is audio_in sampled in the fall-event clk. There is no handshake with the APU; audio_in may change any cycle.
- Timing:
  - Frame period = 64*BCLK_DIV clk cycles.
  - frame_strobe spacing is exactly that once running.
  - First strobe arrives 2*BCLK_DIV clk cycles after enable rises from the idle state (bclk rises at BCLK_DIV, falls at 2*BCLK_DIV).
- enable=0, synchronous effect the next clk, including mid-frame:
  - bclk, lrclk, sdata, div_cnt, bit_cnt forced to 0; frame_strobe 0.
  - tx_word holds.
  - Re-enable restarts the frame from bit_cnt=0; no partial frame is resumed.
- rst mid-frame: immediate return to reset state regardless of clk.
- cpu_clk_en has no effect without the optional feature.

Optional Feature:
APU_I2S_AVG_EN
- Defined:
  - A 2^AVG_LOG2-deep shift history of audio_in is pushed on every cpu_clk_en.
  - Running sum, width 16+AVG_LOG2: sum ← sum + new − oldest, same clk as the push.
  - The latch source is sum >> AVG_LOG2 (box-filter decimation).
  - If a push and a latch coincide, the latch uses the pre-update sum.
  - History and sum reset to 0.
  - enable does not gate the history.
- Undefined: no history registers; latch source is audio_in directly.

Test Plan:
1. rst pulse mid-frame with BCLK_DIV=2, enable=1 → bclk/lrclk/sdata/frame_strobe=0 immediately; after release with enable=1, first frame_strobe at clk 4, then every 128 clks.
2. audio_in=0xFFFF, BCLK_DIV=2 → sdata bits after strobe: 0 then fifteen 1s (left); right slot repeats 0x7FFF; lrclk high for 16 BCLK, low for 16.
3. audio_in=0x8000 → tx_word 0x0000, sdata all 0; audio_in=0x0000 → 0x8000, single 1 at MSB of each slot.
4. audio_in changes 0x1234→0xABCD mid-frame → current frame transmits only the latched word (both slots); the next frame carries 0x2BCD.
5. enable dropped at bit_cnt=9, held 10 clks, re-raised → outputs 0 the next clk; restart at bit_cnt=0; first strobe at 2*BCLK_DIV after re-enable.
6. (APU_I2S_AVG_EN, AVG_LOG2=4) 16 cpu_clk_en pushes of 0x9000 from reset → latched word 0x1000; after 8 pushes, latched word is 0x4800 → 0xC800.
